// File: rtl/host_dma_scheduler_if.sv
// Job-command, DMA-engine and write-response signals between a host-side driver and
// host_dma_scheduler. The scheduler uses the slave modport.
interface host_dma_scheduler_if #(
    parameter int unsigned C_M_AXI_ADDR_WIDTH = 32
);
    logic                          cmd_valid;
    logic                          cmd_ready;
    logic                          cmd_reload_weights;
    logic [31:0]                   cmd_image_num;
    logic [C_M_AXI_ADDR_WIDTH-1:0] cmd_weights_addr;
    logic [C_M_AXI_ADDR_WIDTH-1:0] cmd_src_addr;
    logic [C_M_AXI_ADDR_WIDTH-1:0] cmd_dst_addr;

    logic                          load_weights;
    logic                          model_start;
    logic [31:0]                   image_num;
    logic [C_M_AXI_ADDR_WIDTH-1:0] host_weights_addr;
    logic [C_M_AXI_ADDR_WIDTH-1:0] host_src_addr;
    logic [C_M_AXI_ADDR_WIDTH-1:0] host_dst_addr;

    logic                          ddr_din_eop;
    logic                          m_axi_bvalid;
    logic                          m_axi_bready;
    logic [1:0]                    m_axi_bresp;

    logic                          busy;
    logic                          job_done;
    logic                          resp_err;
    logic                          timeout_err;
    logic                          weights_loaded;

    modport master (
        output cmd_valid, cmd_reload_weights, cmd_image_num,
               cmd_weights_addr, cmd_src_addr, cmd_dst_addr,
               ddr_din_eop, m_axi_bvalid, m_axi_bready, m_axi_bresp,
        input  cmd_ready, load_weights, model_start, image_num,
               host_weights_addr, host_src_addr, host_dst_addr,
               busy, job_done, resp_err, timeout_err, weights_loaded
    );

    modport slave (
        input  cmd_valid, cmd_reload_weights, cmd_image_num,
               cmd_weights_addr, cmd_src_addr, cmd_dst_addr,
               ddr_din_eop, m_axi_bvalid, m_axi_bready, m_axi_bresp,
        output cmd_ready, load_weights, model_start, image_num,
               host_weights_addr, host_src_addr, host_dst_addr,
               busy, job_done, resp_err, timeout_err, weights_loaded
    );
endinterface

// File: rtl/host_dma_scheduler.sv
// Sequences one DMA job: optional weight load, model start, then counts write responses.
// Define HOST_DMA_SCHED_TIMEOUT_EN to add the no-progress watchdog in WAIT_W/RUN.
module host_dma_scheduler #(
    parameter int unsigned C_M_AXI_ADDR_WIDTH  = 32,
    parameter int unsigned OUT_BEATS_PER_IMAGE = 16,
    parameter int unsigned TIMEOUT_CYCLES      = 1048576
) (
    input logic                 clk,
    input logic                 m_axi_aresetn,
    host_dma_scheduler_if.slave bus
);
    typedef enum logic [2:0] {
        StIdle,
        StLoadW,
        StWaitW,
        StStart,
        StRun,
        StDone
    } state_e;

    state_e                        state_q;
    logic                          cmd_ready_q;
    logic                          load_weights_q;
    logic                          model_start_q;
    logic                          job_done_q;
    logic                          busy_q;
    logic                          resp_err_q;
    logic                          weights_loaded_q;
    logic [31:0]                   image_num_q;
    logic [C_M_AXI_ADDR_WIDTH-1:0] weights_addr_q;
    logic [C_M_AXI_ADDR_WIDTH-1:0] src_addr_q;
    logic [C_M_AXI_ADDR_WIDTH-1:0] dst_addr_q;
    logic [39:0]                   target_q;
    logic [39:0]                   resp_cnt_q;

    logic beat;
    assign beat = bus.m_axi_bvalid && bus.m_axi_bready;

`ifdef HOST_DMA_SCHED_TIMEOUT_EN
    logic        timeout_err_q;
    logic [31:0] wd_cnt_q;
    logic        wd_expire;
    assign wd_expire = (wd_cnt_q == 32'(TIMEOUT_CYCLES - 1));
`endif

    always_ff @(posedge clk) begin
        if (!m_axi_aresetn) begin
            state_q          <= StIdle;
            cmd_ready_q      <= 1'b1;
            load_weights_q   <= 1'b0;
            model_start_q    <= 1'b0;
            job_done_q       <= 1'b0;
            busy_q           <= 1'b0;
            resp_err_q       <= 1'b0;
            weights_loaded_q <= 1'b0;
            image_num_q      <= '0;
            weights_addr_q   <= '0;
            src_addr_q       <= '0;
            dst_addr_q       <= '0;
            target_q         <= '0;
            resp_cnt_q       <= '0;
`ifdef HOST_DMA_SCHED_TIMEOUT_EN
            timeout_err_q    <= 1'b0;
            wd_cnt_q         <= '0;
`endif
        end else begin
            load_weights_q <= 1'b0;
            model_start_q  <= 1'b0;
            job_done_q     <= 1'b0;
`ifdef HOST_DMA_SCHED_TIMEOUT_EN
            // Any state outside the waiting ones holds the watchdog at zero.
            wd_cnt_q       <= '0;
`endif
            unique case (state_q)
                StIdle: begin
                    if (bus.cmd_valid) begin
                        image_num_q    <= bus.cmd_image_num;
                        weights_addr_q <= bus.cmd_weights_addr;
                        src_addr_q     <= bus.cmd_src_addr;
                        dst_addr_q     <= bus.cmd_dst_addr;
                        target_q       <= 40'(bus.cmd_image_num) * 40'(OUT_BEATS_PER_IMAGE);
                        resp_err_q     <= 1'b0;
`ifdef HOST_DMA_SCHED_TIMEOUT_EN
                        timeout_err_q  <= 1'b0;
`endif
                        busy_q         <= 1'b1;
                        cmd_ready_q    <= 1'b0;
                        if (bus.cmd_reload_weights || !weights_loaded_q) begin
                            state_q          <= StLoadW;
                            load_weights_q   <= 1'b1;
                            weights_loaded_q <= 1'b0;
                        end else if (bus.cmd_image_num == 32'd0) begin
                            state_q    <= StDone;
                            job_done_q <= 1'b1;
                        end else begin
                            state_q       <= StStart;
                            model_start_q <= 1'b1;
                        end
                    end
                end
                StLoadW: state_q <= StWaitW;
                StWaitW: begin
                    if (bus.ddr_din_eop) begin
                        weights_loaded_q <= 1'b1;
                        if (image_num_q != 32'd0) begin
                            state_q       <= StStart;
                            model_start_q <= 1'b1;
                        end else begin
                            state_q    <= StDone;
                            job_done_q <= 1'b1;
                        end
`ifdef HOST_DMA_SCHED_TIMEOUT_EN
                    end else if (wd_expire) begin
                        timeout_err_q <= 1'b1;
                        state_q       <= StDone;
                        job_done_q    <= 1'b1;
                    end else begin
                        wd_cnt_q <= wd_cnt_q + 32'd1;
`endif
                    end
                end
                StStart: begin
                    resp_cnt_q <= '0;
                    state_q    <= StRun;
                end
                StRun: begin
                    if (beat) begin
                        resp_cnt_q <= resp_cnt_q + 40'd1;
                        if (bus.m_axi_bresp != 2'b00) resp_err_q <= 1'b1;
                        if (resp_cnt_q + 40'd1 == target_q) begin
                            state_q    <= StDone;
                            job_done_q <= 1'b1;
                        end
`ifdef HOST_DMA_SCHED_TIMEOUT_EN
                    end else if (wd_expire) begin
                        timeout_err_q <= 1'b1;
                        state_q       <= StDone;
                        job_done_q    <= 1'b1;
                    end else begin
                        wd_cnt_q <= wd_cnt_q + 32'd1;
`endif
                    end
                end
                StDone: begin
                    state_q     <= StIdle;
                    busy_q      <= 1'b0;
                    cmd_ready_q <= 1'b1;
                end
                default: begin
                    state_q     <= StIdle;
                    busy_q      <= 1'b0;
                    cmd_ready_q <= 1'b1;
                end
            endcase
        end
    end

`ifdef HOST_DMA_SCHED_TIMEOUT_EN
    assign bus.timeout_err = timeout_err_q;
`else
    assign bus.timeout_err = 1'b0;
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

    assign bus.cmd_ready         = cmd_ready_q;
    assign bus.load_weights      = load_weights_q;
    assign bus.model_start       = model_start_q;
    assign bus.job_done          = job_done_q;
    assign bus.busy              = busy_q;
    assign bus.resp_err          = resp_err_q;
    assign bus.weights_loaded    = weights_loaded_q;
    assign bus.image_num         = image_num_q;
    assign bus.host_weights_addr = weights_addr_q;
    assign bus.host_src_addr     = src_addr_q;
    assign bus.host_dst_addr     = dst_addr_q;
endmodule
